clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
Multi-channel programmable clock divider and clock-enable generator. It generalises the fixed power-of-two divider to NUM_CH independent channels, each with a runtime-programmable integer ratio. Each channel produces a near-50% divided clock and a single-cycle enable strobe. It sits at the top of the FFT datapath and feeds stage/sample-rate enables; the strobes are the preferred in-fabric use, and o_clk_div is for pins and debug.

Parameters:
NUM_CH, 4, number of divider channels (>=1)
DIV_W, 8, width of a divide ratio; maximum ratio is 2^DIV_W-1
DEFAULT_DIV, 2, ratio loaded at reset for every channel (2 <= DEFAULT_DIV <= 2^DIV_W-1; enforced by elaboration check)

Ports:
i_clk  in  1  single system clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  global count enable
i_sync  in  1  synchronous phase restart of all channels
i_cfg_valid  in  1  ratio write request
i_cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH))
i_cfg_div  in  DIV_W  requested ratio
o_cfg_ready  out  1  write accepted this cycle when high together with i_cfg_valid
o_cfg_pending  out  NUM_CH  per-channel flag: a new ratio is staged and not yet applied
o_clk_div  out  NUM_CH  registered divided clocks
o_strobe  out  NUM_CH  registered one-cycle enables, one per period

Behaviour:
- One clock and a synchronous active-high reset. Priority order: i_rst > i_sync > i_en.
- Effective ratio R: a value of 0 is stored as 1. HI(R) = R - floor(R/2), so the output is high for ceil(R/2) cycles and low for floor(R/2) cycles.
- Reset values, per channel:
  - R = DEFAULT_DIV, cnt = DEFAULT_DIV-1
  - pending = 0, o_clk_div = 0, o_strobe = 0
- Counting edge (i_en=1, no i_rst/i_sync):
  - If cnt == R-1 (wrap): if pending, R <= P and pending cleared. Then cnt <= 0, o_strobe <= 1, o_clk_div <= 1.
  - Otherwise: cnt <= cnt+1, o_strobe <= 0, o_clk_div <= (cnt+1 < HI(R)).
  - Consequence: the first enabled edge after reset wraps, so o_clk_div rises and o_strobe pulses together.
- i_en=0: cnt, R and o_clk_div hold; o_strobe <= 0. No counts are lost or added.
- i_sync=1 (all channels): pending ratios are applied, cnt <= R_new-1, o_clk_div <= 0, o_strobe <= 0. The next enabled edge wraps every channel simultaneously.
- R=1: wraps every enabled edge, so o_strobe stays high while i_en=1 and o_clk_div is constant 1.
- Config port:
  - o_cfg_ready is combinational: !pending[i_cfg_ch], or 1 when i_cfg_ch >= NUM_CH.
  - Accept = i_cfg_valid & o_cfg_ready. On accept: P[ch] <= i_cfg_div (0 mapped to 1) and pending[ch] <= 1.
  - A write to i_cfg_ch >= NUM_CH is accepted and discarded.
  - An accept on the same edge as that channel's wrap does not apply at that wrap; it applies at the following wrap or i_sync.
  - An accept on the same edge as i_sync is staged and is not applied by that sync.
- Counter width is DIV_W with no overflow: cnt never exceeds R-1.
- Reset mid-operation discards staged ratios and restores all channels to the reset values above.
- All outputs are registered except o_cfg_ready.

Decomposition:
- Package clock_divider_pkg holds:
  - function hi_count(R), returning R - R/2
  - function ch_width(NUM_CH)
  - the zero-to-one ratio mapping function
- Sub-module clock_divider_chan (one channel: R, P, pending, cnt, outputs), generated NUM_CH times.
- The top level holds the config decode, the ready mux and the i_sync/i_en fan-out.

Test Plan:
1. Reset, then i_en=1 with defaults (DEFAULT_DIV=2) -> every o_clk_div runs 1,0,1,0 from the first edge; o_strobe is high on the cycles where o_clk_div is 1; o_cfg_pending=0.
2. Write ch1 with div=5 mid-period -> o_cfg_pending[1]=1 and o_cfg_ready=0 for ch1 until ch1's next wrap. After that wrap, ch1 runs 3 high / 2 low with a strobe every 5 cycles; the other channels are unaffected.
3. Write ch2 with div=0, then ch2 with div=1 -> after the respective wraps, ch2 o_strobe is constant 1 and o_clk_div is constant 1 while i_en=1.
4. With ch0 at ratio 3, drop i_en for 4 cycles at cnt=1 -> o_strobe=0 and o_clk_div held throughout. On resume, ch0 completes its period with exactly 1 more count before the wrap.
5. ch0=3, ch3=4 with ch3 pending 6; assert i_sync -> all o_clk_div and o_strobe are 0 at the next edge. The following enabled edge strobes all channels together; ch3 now runs period 6 and its pending flag is cleared.
6. Assert i_rst and i_sync together with ch1 pending -> reset wins, all ratios return to 2 and pending clears. Then write i_cfg_ch=NUM_CH -> o_cfg_ready=1 and no channel changes.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared helpers for the multi-channel programmable clock divider.
package clock_divider_pkg;

  // Number of high cycles in one period of ratio r (ceil(r/2)).
  function automatic int unsigned hi_count(input int unsigned r);
    return r - (r / 32'd2);
  endfunction

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : int'($clog2(n));
  endfunction

  // A ratio of zero is meaningless; treat it as divide-by-one.
  function automatic int unsigned map_ratio(input int unsigned d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Ratio-configuration port of the programmable clock divider.
interface clock_divider_if import clock_divider_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = int'(ch_width(unsigned'(NUM_CH)));

  logic              i_cfg_valid;
  logic [CH_W-1:0]   i_cfg_ch;
  logic [DIV_W-1:0]  i_cfg_div;
  logic              o_cfg_ready;
  logic [NUM_CH-1:0] o_cfg_pending;

  modport master (
    output i_cfg_valid, i_cfg_ch, i_cfg_div,
    input  o_cfg_ready, o_cfg_pending
  );

  modport slave (
    input  i_cfg_valid, i_cfg_ch, i_cfg_div,
    output o_cfg_ready, o_cfg_pending
  );
endinterface

// File: rtl/clock_divider_chan.sv
// One divider channel: active/staged ratio, period counter, divided clock and strobe.
module clock_divider_chan import clock_divider_pkg::*; #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_pending,
  output logic             o_clk_div,
  output logic             o_strobe
);
  localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO  = {DIV_W{1'b0}};

  logic [DIV_W-1:0] ratio_r;
  logic [DIV_W-1:0] stage_r;
  logic [DIV_W-1:0] cnt_r;
  logic             pending_r;
  logic             clk_div_r;
  logic             strobe_r;

  logic [DIV_W-1:0] ratio_next_s;
  logic [DIV_W-1:0] hi_s;
  logic [DIV_W-1:0] cnt_inc_s;
  logic             wrap_s;

  // Ratio taking effect at the next wrap/sync, wrap detect and high-phase length
  always_comb begin
    if (pending_r) begin
      ratio_next_s = stage_r;
    end else begin
      ratio_next_s = ratio_r;
    end
    wrap_s    = (cnt_r == (ratio_r - ONE));
    hi_s      = DIV_W'(hi_count(32'(ratio_r)));
    cnt_inc_s = cnt_r + ONE;
  end

  // Channel state: reset > sync > enabled count; a staged write lands after the period logic
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ratio_r   <= DEF_R;
      stage_r   <= DEF_R;
      cnt_r     <= DEF_R - ONE;
      pending_r <= 1'b0;
      clk_div_r <= 1'b0;
      strobe_r  <= 1'b0;
    end else begin
      if (i_sync) begin
        ratio_r   <= ratio_next_s;
        cnt_r     <= ratio_next_s - ONE;
        pending_r <= 1'b0;
        clk_div_r <= 1'b0;
        strobe_r  <= 1'b0;
      end else if (i_en) begin
        if (wrap_s) begin
          ratio_r   <= ratio_next_s;
          pending_r <= 1'b0;
          cnt_r     <= ZERO;
          strobe_r  <= 1'b1;
          clk_div_r <= 1'b1;
        end else begin
          cnt_r     <= cnt_inc_s;
          strobe_r  <= 1'b0;
          clk_div_r <= (cnt_inc_s < hi_s);
        end
      end else begin
        strobe_r <= 1'b0;
      end
      // Only accepted while not pending, so it never races the apply above.
      if (i_wr) begin
        stage_r   <= i_wr_div;
        pending_r <= 1'b1;
      end
    end
  end

  assign o_pending = pending_r;
  assign o_clk_div = clk_div_r;
  assign o_strobe  = strobe_r;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider / clock-enable generator.
module clock_divider_prog import clock_divider_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_sync,
  clock_divider_if.slave    cfg,
  output logic [NUM_CH-1:0] o_clk_div,
  output logic [NUM_CH-1:0] o_strobe
);
  localparam int CH_W  = int'(ch_width(unsigned'(NUM_CH)));
  localparam int PAD_N = 1 << CH_W;

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if ((DEFAULT_DIV < 2) || (DEFAULT_DIV > ((2 ** DIV_W) - 1))) begin : g_bad_default
    $error("DEFAULT_DIV must lie in 2 .. 2**DIV_W-1");
  end

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] wr_s;
  logic [PAD_N-1:0]  pend_pad_s;
  logic [DIV_W-1:0]  wr_div_s;
  logic              ready_s;

  // Ready mux and write decode; unused channel codes read as never-pending
  always_comb begin
    pend_pad_s               = {PAD_N{1'b0}};
    pend_pad_s[NUM_CH-1:0]   = pending_s;
    ready_s                  = ~pend_pad_s[cfg.i_cfg_ch];
    wr_div_s                 = DIV_W'(map_ratio(32'(cfg.i_cfg_div)));
    for (int i = 0; i < NUM_CH; i++) begin
      wr_s[i] = cfg.i_cfg_valid & ready_s & (cfg.i_cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clock_divider_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_sync    (i_sync),
      .i_wr      (wr_s[g]),
      .i_wr_div  (wr_div_s),
      .o_pending (pending_s[g]),
      .o_clk_div (o_clk_div[g]),
      .o_strobe  (o_strobe[g])
    );
  end

  assign cfg.o_cfg_ready   = ready_s;
  assign cfg.o_cfg_pending = pending_s;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog with a period-level reference model.
module tb_clock_divider_prog;
  localparam int NUM_CH      = 5;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              sync;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] strobe;

  clock_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg ();

  clock_divider_prog #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_sync    (sync),
    .cfg       (cfg),
    .o_clk_div (clk_div),
    .o_strobe  (strobe)
  );

  always #5 clk = ~clk;

  // Model: active ratio, staged ratio, position within the current period
  int m_r    [NUM_CH];
  int m_p    [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_primed [NUM_CH];
  bit m_live [NUM_CH];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) e[c] = !m_primed[c] && (m_pos[c] < (m_r[c] + 1) / 2);
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_stb();
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) e[c] = m_live[c] && (m_pos[c] == 0);
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_pend();
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) e[c] = m_pend[c];
    return e;
  endfunction

  function automatic logic exp_ready();
    int ch = int'(cfg.i_cfg_ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int ch;
    bit acc;
    ch  = int'(cfg.i_cfg_ch);
    acc = cfg.i_cfg_valid && ((ch >= NUM_CH) || !m_pend[ch]);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_r[c] = DEFAULT_DIV; m_pos[c] = DEFAULT_DIV - 1;
        m_pend[c] = 1'b0; m_primed[c] = 1'b1; m_live[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync) begin
          if (m_pend[c]) begin m_r[c] = m_p[c]; m_pend[c] = 1'b0; end
          m_pos[c] = m_r[c] - 1; m_primed[c] = 1'b1; m_live[c] = 1'b0;
        end else if (en) begin
          m_pos[c] = m_pos[c] + 1;
          if (m_pos[c] >= m_r[c]) begin
            if (m_pend[c]) begin m_r[c] = m_p[c]; m_pend[c] = 1'b0; end
            m_pos[c] = 0;
          end
          m_primed[c] = 1'b0; m_live[c] = 1'b1;
        end else begin
          m_live[c] = 1'b0;
        end
      end
      if (acc && ch < NUM_CH) begin
        m_p[ch]    = (cfg.i_cfg_div == 8'd0) ? 1 : int'(cfg.i_cfg_div);
        m_pend[ch] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg_write(input int ch, input int div);
    cfg.i_cfg_valid = 1'b1;
    cfg.i_cfg_ch    = 3'(ch);
    cfg.i_cfg_div   = 8'(div);
    tick();
    cfg.i_cfg_valid = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("clk_div", 8'(clk_div), 8'(exp_clk()));
      check("strobe", 8'(strobe), 8'(exp_stb()));
      check("pending", 8'(cfg.o_cfg_pending), 8'(exp_pend()));
      check("cfg_ready", 8'(cfg.o_cfg_ready), 8'(exp_ready()));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] seq;
    int n;
    rst = 1'b1; en = 1'b0; sync = 1'b0;
    cfg.i_cfg_valid = 1'b0; cfg.i_cfg_ch = 3'd0; cfg.i_cfg_div = 8'd0;
    tick(); tick();
    chk_on = 1'b1;
    check("rst_clk", 8'(clk_div), 8'h00);
    check("rst_stb", 8'(strobe), 8'h00);
    check("rst_pend", 8'(cfg.o_cfg_pending), 8'h00);

    // Defaults: divide by two from the first enabled edge
    rst = 1'b0; en = 1'b1;
    tick(); check("def_clk1", 8'(clk_div), 8'h1F); check("def_stb1", 8'(strobe), 8'h1F);
    tick(); check("def_clk2", 8'(clk_div), 8'h00); check("def_stb2", 8'(strobe), 8'h00);
    tick(); check("def_clk3", 8'(clk_div), 8'h1F);

    // ch1 -> 5, written mid-period; applies at the next wrap
    cfg_write(1, 5);
    check("c1_pend", 8'(cfg.o_cfg_pending), 8'h02);
    cfg.i_cfg_ch = 3'd1; #1;
    check("c1_ready", 8'(cfg.o_cfg_ready), 8'h00);
    tick();
    check("c1_apply", 8'(cfg.o_cfg_pending), 8'h00);
    check("c1_stb", 8'(strobe[1]), 8'h01);
    seq = 5'd0;
    for (int i = 0; i < 5; i++) begin tick(); seq = {seq[3:0], clk_div[1]}; end
    check("c1_shape", 8'(seq), 8'h19);

    // ch2 -> 0 (stored as 1), then -> 1
    cfg_write(2, 0);
    repeat (2) tick();
    check("c2_pend0", 8'(cfg.o_cfg_pending[2]), 8'h00);
    cfg_write(2, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c2_stb", 8'(strobe[2]), 8'h01);
      check("c2_clk", 8'(clk_div[2]), 8'h01);
    end

    // ch0 -> 3, pause at position 1 for four cycles
    cfg_write(0, 3);
    repeat (3) tick();
    for (int i = 0; i < 6 && m_pos[0] != 1; i++) tick();
    check("c0_align", 8'(m_pos[0]), 8'h01);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_stb", 8'(strobe[0]), 8'h00);
      check("hold_clk", 8'(clk_div[0]), 8'h01);
    end
    en = 1'b1;
    tick(); check("resume_stb", 8'(strobe[0]), 8'h00); check("resume_clk", 8'(clk_div[0]), 8'h00);
    tick(); check("resume_wrap", 8'(strobe[0]), 8'h01);

    // ch3 -> 4, then stage 6 and sync; ch0 write lands on the sync edge
    cfg_write(3, 4);
    repeat (3) tick();
    en = 1'b0;
    cfg_write(3, 6);
    check("c3_pend", 8'(cfg.o_cfg_pending[3]), 8'h01);
    sync = 1'b1;
    cfg_write(0, 4);
    sync = 1'b0;
    check("sync_clk", 8'(clk_div), 8'h00);
    check("sync_stb", 8'(strobe), 8'h00);
    check("sync_pend", 8'(cfg.o_cfg_pending), 8'h01);
    en = 1'b1;
    tick();
    check("sync_wrap_stb", 8'(strobe), 8'h1F);
    check("sync_wrap_clk", 8'(clk_div), 8'h1F);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (strobe[3]) break;
    end
    check("c3_period", 8'(n), 8'h06);

    // Reset beats sync and drops a staged ratio
    en = 1'b0;
    cfg_write(1, 9);
    check("c1_pend9", 8'(cfg.o_cfg_pending[1]), 8'h01);
    rst = 1'b1; sync = 1'b1;
    tick();
    rst = 1'b0; sync = 1'b0;
    check("rst2_pend", 8'(cfg.o_cfg_pending), 8'h00);
    check("rst2_clk", 8'(clk_div), 8'h00);
    en = 1'b1;
    tick(); check("rst2_clk1", 8'(clk_div), 8'h1F);
    tick(); check("rst2_clk2", 8'(clk_div), 8'h00);

    // Out-of-range channel codes are accepted and discarded
    cfg.i_cfg_valid = 1'b1; cfg.i_cfg_ch = 3'd5; cfg.i_cfg_div = 8'd7; #1;
    check("oor_ready5", 8'(cfg.o_cfg_ready), 8'h01);
    tick();
    cfg.i_cfg_ch = 3'd7; #1;
    check("oor_ready7", 8'(cfg.o_cfg_ready), 8'h01);
    tick();
    cfg.i_cfg_valid = 1'b0;
    check("oor_pend", 8'(cfg.o_cfg_pending), 8'h00);
    repeat (8) tick();
    check("oor_clk", 8'(clk_div), 8'h00);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
